// File: rtl/riscv_base_exec.sv
// Single-stage RV32I execute unit: ALU, branch/jump resolution and a registered result stage.
// Optional build macro: RISCV_BASE_EXEC_BYPASS_EN forwards the held result to operands a/b.
module riscv_base_exec #(
    parameter int unsigned MISALIGN_FAULT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_rs1_idx_i,
    input  logic [4:0]  opcode_rs2_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        stall_i,
    output logic        accept_o,
    output logic        writeback_valid_o,
    output logic [4:0]  writeback_rd_idx_o,
    output logic [31:0] writeback_value_o,
    output logic        branch_request_o,
    output logic [31:0] branch_pc_o,
    output logic        fault_misaligned_o
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // The two compare codes are crossed on purpose: LessThan is unsigned, LessThanUnsigned signed.
    localparam logic [3:0] AluAdd              = 4'd0;
    localparam logic [3:0] AluSub              = 4'd1;
    localparam logic [3:0] AluShiftLeft        = 4'd2;
    localparam logic [3:0] AluShiftRight       = 4'd3;
    localparam logic [3:0] AluShiftRightArith  = 4'd4;
    localparam logic [3:0] AluAnd              = 4'd5;
    localparam logic [3:0] AluOr               = 4'd6;
    localparam logic [3:0] AluXor              = 4'd7;
    localparam logic [3:0] AluLessThan         = 4'd8;
    localparam logic [3:0] AluLessThanUnsigned = 4'd9;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_value_q, wb_value_d;
    logic        br_req_q, br_req_d;
    logic [31:0] br_pc_q, br_pc_d;
    logic        fault_q, fault_d;

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_u, imm_j, imm_b;
    logic [31:0] op_a, op_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        wb_en, use_pc4, taken;
    logic [31:0] target, result, pc_plus4;
    logic        cmp_signed, cmp_lt, cmp_eq;
    logic [32:0] cmp_diff;
    logic        exec_en, fault_now;

    assign opc    = opcode_opcode_i[6:0];
    assign funct3 = opcode_opcode_i[14:12];
    assign funct7 = opcode_opcode_i[31:25];

    assign imm_i = {{20{opcode_opcode_i[31]}}, opcode_opcode_i[31:20]};
    assign imm_u = {opcode_opcode_i[31:12], 12'b0};
    assign imm_j = {{12{opcode_opcode_i[31]}}, opcode_opcode_i[19:12], opcode_opcode_i[20],
                    opcode_opcode_i[30:21], 1'b0};
    assign imm_b = {{20{opcode_opcode_i[31]}}, opcode_opcode_i[7], opcode_opcode_i[30:25],
                    opcode_opcode_i[11:8], 1'b0};

`ifdef RISCV_BASE_EXEC_BYPASS_EN
    assign op_a = (wb_valid_q && wb_rd_q == opcode_rs1_idx_i && wb_rd_q != 5'd0) ?
                  wb_value_q : opcode_ra_operand_i;
    assign op_b = (wb_valid_q && wb_rd_q == opcode_rs2_idx_i && wb_rd_q != 5'd0) ?
                  wb_value_q : opcode_rb_operand_i;
`else
    logic unused_idx;
    assign unused_idx = ^{opcode_rs1_idx_i, opcode_rs2_idx_i};
    assign op_a = opcode_ra_operand_i;
    assign op_b = opcode_rb_operand_i;
`endif

    assign accept_o  = ~stall_i;
    assign exec_en   = opcode_valid_i & accept_o & ~br_req_q;
    assign pc_plus4  = opcode_pc_i + 32'd4;

    // Branch compare: 33-bit subtract, sign bit of the difference is "less than".
    assign cmp_signed = ~funct3[1];
    assign cmp_diff   = {cmp_signed & op_a[31], op_a} - {cmp_signed & op_b[31], op_b};
    assign cmp_lt     = cmp_diff[32];
    assign cmp_eq     = (op_a == op_b);

    always_comb begin
        alu_op  = AluAdd;
        alu_a   = op_a;
        alu_b   = imm_i;
        wb_en   = 1'b0;
        use_pc4 = 1'b0;
        taken   = 1'b0;
        target  = 32'd0;
        unique case (opc)
            OpcOp: begin
                alu_b = op_b;
                unique case (funct3)
                    3'b000: begin
                        alu_op = funct7[5] ? AluSub : AluAdd;
                        wb_en  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b001: begin
                        alu_op = AluShiftLeft;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    3'b010: begin
                        alu_op = AluLessThanUnsigned;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    3'b011: begin
                        alu_op = AluLessThan;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    3'b100: begin
                        alu_op = AluXor;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        alu_op = funct7[5] ? AluShiftRightArith : AluShiftRight;
                        wb_en  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b110: begin
                        alu_op = AluOr;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    default: begin
                        alu_op = AluAnd;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                endcase
            end
            OpcOpImm: begin
                wb_en = 1'b1;
                unique case (funct3)
                    3'b000: alu_op = AluAdd;
                    3'b001: begin
                        alu_op = AluShiftLeft;
                        wb_en  = (funct7 == 7'b0000000);
                    end
                    3'b010: alu_op = AluLessThanUnsigned;
                    3'b011: alu_op = AluLessThan;
                    3'b100: alu_op = AluXor;
                    3'b101: begin
                        alu_op = funct7[5] ? AluShiftRightArith : AluShiftRight;
                        wb_en  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b110: alu_op = AluOr;
                    default: alu_op = AluAnd;
                endcase
            end
            OpcLui: begin
                alu_a = 32'd0;
                alu_b = imm_u;
                wb_en = 1'b1;
            end
            OpcAuipc: begin
                alu_a = opcode_pc_i;
                alu_b = imm_u;
                wb_en = 1'b1;
            end
            OpcJal: begin
                wb_en   = 1'b1;
                use_pc4 = 1'b1;
                taken   = 1'b1;
                target  = opcode_pc_i + imm_j;
            end
            OpcJalr: begin
                wb_en   = (funct3 == 3'b000);
                use_pc4 = 1'b1;
                taken   = (funct3 == 3'b000);
                target  = (op_a + imm_i) & ~32'd1;
            end
            OpcBranch: begin
                target = opcode_pc_i + imm_b;
                unique case (funct3)
                    3'b000:  taken = cmp_eq;
                    3'b001:  taken = ~cmp_eq;
                    3'b100:  taken = cmp_lt;
                    3'b101:  taken = ~cmp_lt;
                    3'b110:  taken = cmp_lt;
                    3'b111:  taken = ~cmp_lt;
                    default: taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        unique case (alu_op)
            AluAdd:              alu_res = alu_a + alu_b;
            AluSub:              alu_res = alu_a - alu_b;
            AluShiftLeft:        alu_res = alu_a << alu_b[4:0];
            AluShiftRight:       alu_res = alu_a >> alu_b[4:0];
            AluShiftRightArith:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            AluAnd:              alu_res = alu_a & alu_b;
            AluOr:               alu_res = alu_a | alu_b;
            AluXor:              alu_res = alu_a ^ alu_b;
            AluLessThan:         alu_res = {31'd0, alu_a < alu_b};
            AluLessThanUnsigned: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default:             alu_res = 32'd0;
        endcase
    end

    assign result    = use_pc4 ? pc_plus4 : alu_res;
    assign fault_now = taken & target[1] & (MISALIGN_FAULT != 0);

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_value_d = wb_value_q;
        br_pc_d    = br_pc_q;
        br_req_d   = 1'b0;
        fault_d    = 1'b0;
        if (!stall_i) begin
            wb_valid_d = 1'b0;
            if (exec_en) begin
                wb_valid_d = wb_en & (opcode_rd_idx_i != 5'd0) & ~fault_now;
                wb_rd_d    = opcode_rd_idx_i;
                wb_value_d = result;
                br_req_d   = taken & ~fault_now;
                fault_d    = fault_now;
                if (taken) begin
                    br_pc_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_value_q <= 32'd0;
            br_req_q   <= 1'b0;
            br_pc_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_value_q <= wb_value_d;
            br_req_q   <= br_req_d;
            br_pc_q    <= br_pc_d;
            fault_q    <= fault_d;
        end
    end

    assign writeback_valid_o  = wb_valid_q;
    assign writeback_rd_idx_o = wb_rd_q;
    assign writeback_value_o  = wb_value_q;
    assign branch_request_o   = br_req_q;
    assign branch_pc_o        = br_pc_q;
    assign fault_misaligned_o = fault_q;

endmodule
